// File: rtl/play_session_ctrl.sv
// Play-mode session sequencer: menu select, countdown, play window, result hold.
// All outputs registered; a button pulse shows on the outputs after the next clk edge.
module play_session_ctrl #(
  parameter int TICK_DIV    = 100_000_000,
  parameter int COUNTDOWN_S = 3,
  parameter int RESULT_S    = 5,
  parameter int SONG_NUM    = 4,
  parameter int DIFF_MAX    = 9,
  parameter int MOD_NUM     = 3,
  parameter int SONG_BITS   = (SONG_NUM > 1) ? $clog2(SONG_NUM) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_confirm,
  input  logic                 btn_back,
  input  logic                 btn_next,
  input  logic                 btn_prev,
  input  logic                 song_over,
  output logic                 play_en,
  output logic [SONG_BITS-1:0] song_sel,
  output logic [1:0]           mod_sel,
  output logic [3:0]           diff_sel,
  output logic [1:0]           field,
  output logic [3:0]           count_digit,
  output logic [2:0]           state
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]        TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SONG_BITS-1:0] SONG_LAST = SONG_BITS'(SONG_NUM - 1);
  localparam logic [1:0]           MOD_LAST  = 2'(MOD_NUM - 1);
  localparam logic [3:0]           DIFF_TOP  = 4'(DIFF_MAX);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_COUNT  = 3'd2,
    S_RUN    = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  state_t               st_q, st_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [1:0]           field_q, field_d;
  logic [SONG_BITS-1:0] song_q, song_d;
  logic [1:0]           mod_q, mod_d;
  logic [3:0]           diff_q, diff_d;
  logic [3:0]           digit_q, digit_d;
  logic                 play_q, play_d;

  logic tick;
  logic step_up;
  logic step_dn;

  assign tick    = (tick_q == TICK_LAST);
  // next and prev in the same cycle cancel each other
  assign step_up = btn_next & ~btn_prev;
  assign step_dn = btn_prev & ~btn_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= S_IDLE;
      tick_q  <= '0;
      field_q <= 2'd0;
      song_q  <= '0;
      mod_q   <= 2'd0;
      diff_q  <= 4'd1;
      digit_q <= 4'd0;
      play_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      tick_q  <= tick_d;
      field_q <= field_d;
      song_q  <= song_d;
      mod_q   <= mod_d;
      diff_q  <= diff_d;
      digit_q <= digit_d;
      play_q  <= play_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    field_d = field_q;
    song_d  = song_q;
    mod_d   = mod_q;
    diff_d  = diff_q;
    digit_d = digit_q;

    case (st_q)
      S_IDLE: begin
        if (!btn_back && btn_confirm) begin
          st_d    = S_SELECT;
          field_d = 2'd0;
        end
      end

      S_SELECT: begin
        if (btn_back) begin
          if (field_q == 2'd0) st_d = S_IDLE;
          else                 field_d = field_q - 2'd1;
        end else if (btn_confirm) begin
          if (field_q >= 2'd2) begin
            st_d    = S_COUNT;
            digit_d = 4'(COUNTDOWN_S);
          end else begin
            field_d = field_q + 2'd1;
          end
        end else if (step_up || step_dn) begin
          case (field_q)
            2'd0: begin
              if (step_up) song_d = (song_q == SONG_LAST) ? '0 : song_q + 1'b1;
              else         song_d = (song_q == '0) ? SONG_LAST : song_q - 1'b1;
            end
            2'd1: begin
              if (step_up) mod_d = (mod_q == MOD_LAST) ? 2'd0 : mod_q + 2'd1;
              else         mod_d = (mod_q == 2'd0) ? MOD_LAST : mod_q - 2'd1;
            end
            2'd2: begin
              if (step_up) diff_d = (diff_q >= DIFF_TOP) ? 4'd1 : diff_q + 4'd1;
              else         diff_d = (diff_q <= 4'd1) ? DIFF_TOP : diff_q - 4'd1;
            end
            default: ;
          endcase
        end
      end

      S_COUNT: begin
        if (btn_back) begin
          st_d    = S_SELECT;
          field_d = 2'd2;
          digit_d = 4'd0;
        end else if (tick) begin
          if (digit_q <= 4'd1) begin
            st_d    = S_RUN;
            digit_d = 4'd0;
          end else begin
            digit_d = digit_q - 4'd1;
          end
        end
      end

      S_RUN: begin
        if (btn_back) begin
          st_d = S_IDLE;
        end else if (song_over) begin
          st_d    = S_RESULT;
          digit_d = 4'(RESULT_S);
        end
      end

      S_RESULT: begin
        if (btn_back || btn_confirm) begin
          st_d    = S_IDLE;
          digit_d = 4'd0;
        end else if (tick) begin
          if (digit_q <= 4'd1) begin
            st_d    = S_IDLE;
            digit_d = 4'd0;
          end else begin
            digit_d = digit_q - 4'd1;
          end
        end
      end

      default: begin
        st_d    = S_IDLE;
        digit_d = 4'd0;
      end
    endcase
  end

  // every state entry restarts the second so the first one is full length
  always_comb begin
    tick_d = '0;
    if (st_d == st_q && (st_q == S_COUNT || st_q == S_RESULT))
      tick_d = tick ? '0 : tick_q + 1'b1;
  end

  assign play_d = (st_d == S_RUN);

  assign state       = st_q;
  assign play_en     = play_q;
  assign song_sel    = song_q;
  assign mod_sel     = mod_q;
  assign diff_sel    = diff_q;
  assign field       = field_q;
  assign count_digit = digit_q;

endmodule

// File: tb/tb_play_session_ctrl.sv
// Bench for play_session_ctrl: directed scenarios plus random buttons against a time-based model.
module tb_play_session_ctrl;

  localparam int TICK_DIV    = 10;
  localparam int COUNTDOWN_S = 3;
  localparam int RESULT_S    = 5;
  localparam int SONG_NUM    = 4;
  localparam int DIFF_MAX    = 9;
  localparam int MOD_NUM     = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_confirm = 1'b0, btn_back = 1'b0, btn_next = 1'b0, btn_prev = 1'b0;
  logic       song_over = 1'b0;
  logic       play_en;
  logic [1:0] song_sel;
  logic [1:0] mod_sel;
  logic [3:0] diff_sel;
  logic [1:0] field;
  logic [3:0] count_digit;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  // model: state number, cursor, selections and cycles spent in the current state
  int m_state, m_field, m_song, m_mod, m_diff, m_n;

  play_session_ctrl #(
    .TICK_DIV(TICK_DIV), .COUNTDOWN_S(COUNTDOWN_S), .RESULT_S(RESULT_S),
    .SONG_NUM(SONG_NUM), .DIFF_MAX(DIFF_MAX), .MOD_NUM(MOD_NUM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_confirm(btn_confirm), .btn_back(btn_back),
    .btn_next(btn_next), .btn_prev(btn_prev), .song_over(song_over),
    .play_en(play_en), .song_sel(song_sel), .mod_sel(mod_sel),
    .diff_sel(diff_sel), .field(field), .count_digit(count_digit), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_field = 0; m_song = 0; m_mod = 0; m_diff = 1; m_n = 0;
  endtask

  function automatic int model_digit();
    if (m_state == 2) return COUNTDOWN_S - m_n / TICK_DIV;
    if (m_state == 4) return RESULT_S - m_n / TICK_DIV;
    return 0;
  endfunction

  task automatic model_edge();
    int ns;
    ns = m_state;
    case (m_state)
      0: if (!btn_back && btn_confirm) begin ns = 1; m_field = 0; end
      1: begin
        if (btn_back) begin
          if (m_field == 0) ns = 0; else m_field = m_field - 1;
        end else if (btn_confirm) begin
          if (m_field == 2) ns = 2; else m_field = m_field + 1;
        end else if (btn_next != btn_prev) begin
          if (m_field == 0) m_song = btn_next ? (m_song + 1) % SONG_NUM : (m_song + SONG_NUM - 1) % SONG_NUM;
          if (m_field == 1) m_mod  = btn_next ? (m_mod + 1) % MOD_NUM : (m_mod + MOD_NUM - 1) % MOD_NUM;
          if (m_field == 2) m_diff = btn_next ? (m_diff % DIFF_MAX) + 1 : ((m_diff + DIFF_MAX - 2) % DIFF_MAX) + 1;
        end
      end
      2: begin
        if (btn_back) begin ns = 1; m_field = 2; end
        else if (m_n + 1 == COUNTDOWN_S * TICK_DIV) ns = 3;
      end
      3: if (btn_back) ns = 0; else if (song_over) ns = 4;
      4: if (btn_back || btn_confirm || (m_n + 1 == RESULT_S * TICK_DIV)) ns = 0;
      default: ns = 0;
    endcase
    if (ns != m_state) m_n = 0; else m_n = m_n + 1;
    m_state = ns;
  endtask

  task automatic compare_all();
    chk("state",  32'(state),       32'(m_state));
    chk("play",   32'(play_en),     32'(m_state == 3));
    chk("song",   32'(song_sel),    32'(m_song));
    chk("mod",    32'(mod_sel),     32'(m_mod));
    chk("diff",   32'(diff_sel),    32'(m_diff));
    chk("field",  32'(field),       32'(m_field));
    chk("digit",  32'(count_digit), 32'(model_digit()));
  endtask

  // btns = {confirm, back, next, prev, song_over}
  task automatic cyc(input logic [4:0] btns);
    {btn_confirm, btn_back, btn_next, btn_prev, song_over} = btns;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    {btn_confirm, btn_back, btn_next, btn_prev, song_over} = 5'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(5'b0);
  endtask

  // from IDLE, walk the menu and sit through the countdown into RUN
  task automatic go_run();
    for (int i = 0; i < 4; i++) cyc(5'b10000);
    idle_cycles(COUNTDOWN_S * TICK_DIV);
    chk("go_run_state", 32'(state), 32'd3);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_play",  32'(play_en), 32'd0);
    chk("rst_diff",  32'(diff_sel), 32'd1);
    chk("rst_song",  32'(song_sel), 32'd0);
    chk("rst_digit", 32'(count_digit), 32'd0);
    rst_n = 1'b1;

    // non-confirm buttons in IDLE do nothing
    cyc(5'b01111);
    chk("idle_ignore", 32'(state), 32'd0);

    // menu wrap-around
    cyc(5'b10000);
    chk("enter_select", 32'(state), 32'd1);
    cyc(5'b00010);
    chk("song_prev_wrap", 32'(song_sel), 32'd3);
    cyc(5'b00100);
    cyc(5'b00100);
    chk("song_next2", 32'(song_sel), 32'd1);
    cyc(5'b00110);
    chk("next_prev_both", 32'(song_sel), 32'd1);
    cyc(5'b10000);
    cyc(5'b00100);
    chk("mod_next", 32'(mod_sel), 32'd1);
    cyc(5'b10000);
    chk("field2", 32'(field), 32'd2);
    cyc(5'b00010);
    chk("diff_prev_wrap", 32'(diff_sel), 32'd9);
    cyc(5'b00100);
    chk("diff_next_wrap", 32'(diff_sel), 32'd1);
    cyc(5'b00100);

    // countdown timing
    cyc(5'b10000);
    chk("cd_entry", 32'(count_digit), 32'd3);
    for (int k = 1; k <= COUNTDOWN_S * TICK_DIV; k++) begin
      cyc(5'b0);
      if (k == 9)  chk("cd_digit3_end", 32'(count_digit), 32'd3);
      if (k == 10) chk("cd_digit2", 32'(count_digit), 32'd2);
      if (k == 20) chk("cd_digit1", 32'(count_digit), 32'd1);
      if (k == 29) chk("cd_not_run", 32'(state), 32'd2);
    end
    chk("run_at_30", 32'(state), 32'd3);
    chk("play_at_30", 32'(play_en), 32'd1);

    // selections frozen in RUN, back beats song_over
    cyc(5'b00100);
    cyc(5'b00010);
    chk("run_frozen_song", 32'(song_sel), 32'd1);
    chk("run_frozen_diff", 32'(diff_sel), 32'd2);
    cyc(5'b01001);
    chk("back_beats_over", 32'(state), 32'd0);
    chk("abort_play", 32'(play_en), 32'd0);

    // result expiry
    go_run();
    cyc(5'b00001);
    chk("result_entry", 32'(state), 32'd4);
    chk("result_digit", 32'(count_digit), 32'd5);
    idle_cycles(RESULT_S * TICK_DIV - 1);
    chk("result_hold", 32'(state), 32'd4);
    cyc(5'b0);
    chk("result_expire", 32'(state), 32'd0);

    // result early confirm
    go_run();
    cyc(5'b00001);
    idle_cycles(6);
    cyc(5'b10000);
    chk("result_confirm", 32'(state), 32'd0);

    // back out of countdown
    for (int i = 0; i < 4; i++) cyc(5'b10000);
    idle_cycles(12);
    cyc(5'b01000);
    chk("cd_back_state", 32'(state), 32'd1);
    chk("cd_back_field", 32'(field), 32'd2);
    cyc(5'b01000);
    cyc(5'b01000);
    cyc(5'b01000);
    chk("select_back_idle", 32'(state), 32'd0);

    // async reset in the middle of RUN
    go_run();
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_play",  32'(play_en), 32'd0);
    chk("async_diff",  32'(diff_sel), 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(5'b0);

    // random buttons against the model
    for (int i = 0; i < 4000; i++) begin
      logic [4:0] b;
      b[4] = ($urandom_range(0, 7) == 0);
      b[3] = ($urandom_range(0, 39) == 0);
      b[2] = ($urandom_range(0, 3) == 0);
      b[1] = ($urandom_range(0, 3) == 0);
      b[0] = ($urandom_range(0, 19) == 0);
      cyc(b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
